// File: rtl/frame_timing_gen.sv
// Frame / line / data-valid timing generator for a camera-style video interface.
// Every output is a flop loaded from the next-state decode, so enable never reaches an output combinationally.
`timescale 1ns/1ps
module frame_timing_gen #(
    parameter int DVAL_HIGH = 640,
    parameter int ROW_COUNT = 480,
    parameter int H_FRONT   = 8,
    parameter int H_BACK    = 8,
    parameter int LINE_GAP  = 16,
    parameter int FRAME_GAP = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        fval,
    output logic        lval,
    output logic        dval,
    output logic        fval_posedge,
    output logic        lval_negedge,
    output logic [15:0] pix_x,
    output logic [15:0] line_idx,
    output logic [15:0] frame_cnt
);

    localparam logic [15:0] FGAP_LAST  = 16'(FRAME_GAP - 1);
    localparam logic [15:0] FRONT_LAST = 16'(H_FRONT - 1);
    localparam logic [15:0] ACT_LAST   = 16'(DVAL_HIGH - 1);
    localparam logic [15:0] BACK_LAST  = 16'(H_BACK - 1);
    localparam logic [15:0] LGAP_LAST  = 16'(LINE_GAP - 1);
    localparam logic [15:0] LAST_LINE  = 16'(ROW_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FGAP   = 3'd1,
        S_LPRE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_LPOST  = 3'd4,
        S_LGAP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] line_q, line_d;
    logic [15:0] pix_q, pix_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        fval_q, fval_d;
    logic        lval_q, lval_d;
    logic        dval_q, dval_d;
    logic        fpos_q, fpos_d;
    logic        lneg_q, lneg_d;

    // Phase sequencing: cnt_q counts cycles spent in the current phase and restarts at 0 on every transition
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        line_d      = line_q;
        frame_cnt_d = frame_cnt_q;
        fpos_d      = 1'b0;
        lneg_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (enable) begin
                    state_d = S_FGAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FGAP: begin
                if (cnt_q == FGAP_LAST) begin
                    state_d     = S_LPRE;
                    cnt_d       = 16'd0;
                    line_d      = 16'd0;
                    fpos_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    state_d = S_FGAP;
                end
            end
            S_LPRE: begin
                if (cnt_q == FRONT_LAST) begin
                    state_d = S_ACTIVE;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = S_LPRE;
                end
            end
            S_ACTIVE: begin
                if (cnt_q == ACT_LAST) begin
                    state_d = S_LPOST;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            S_LPOST: begin
                if (cnt_q == BACK_LAST) begin
                    cnt_d  = 16'd0;
                    lneg_d = 1'b1;
                    // The end-of-frame decision samples enable only here, so a frame is never cut short
                    if (line_q < LAST_LINE) begin
                        state_d = S_LGAP;
                        line_d  = line_q + 16'd1;
                    end else if (enable) begin
                        state_d = S_FGAP;
                        line_d  = 16'd0;
                    end else begin
                        state_d = S_IDLE;
                        line_d  = 16'd0;
                    end
                end else begin
                    state_d = S_LPOST;
                end
            end
            S_LGAP: begin
                if (cnt_q == LGAP_LAST) begin
                    state_d = S_LPRE;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = S_LGAP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
                line_d  = 16'd0;
            end
        endcase
    end

    // Output decode from the next state, so the output flops line up with state_q
    always_comb begin
        fval_d = 1'b0;
        lval_d = 1'b0;
        dval_d = 1'b0;
        pix_d  = 16'd0;
        case (state_d)
            S_LPRE, S_LPOST: begin
                fval_d = 1'b1;
                lval_d = 1'b1;
            end
            S_ACTIVE: begin
                fval_d = 1'b1;
                lval_d = 1'b1;
                dval_d = 1'b1;
                pix_d  = cnt_d;
            end
            S_LGAP: begin
                fval_d = 1'b1;
            end
            default: begin
                fval_d = 1'b0;
                lval_d = 1'b0;
                dval_d = 1'b0;
                pix_d  = 16'd0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            line_q      <= 16'd0;
            pix_q       <= 16'd0;
            frame_cnt_q <= 16'd0;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            dval_q      <= 1'b0;
            fpos_q      <= 1'b0;
            lneg_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            pix_q       <= pix_d;
            frame_cnt_q <= frame_cnt_d;
            fval_q      <= fval_d;
            lval_q      <= lval_d;
            dval_q      <= dval_d;
            fpos_q      <= fpos_d;
            lneg_q      <= lneg_d;
        end
    end

    assign fval         = fval_q;
    assign lval         = lval_q;
    assign dval         = dval_q;
    assign fval_posedge = fpos_q;
    assign lval_negedge = lneg_q;
    assign pix_x        = pix_q;
    assign line_idx     = line_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_frame_timing_gen.sv
// Bench for frame_timing_gen: a queue of expected per-cycle outputs built from the frame structure,
// checked every falling edge, plus per-scenario directed checks. Instance B has ROW_COUNT=1.
`timescale 1ns/1ps
module tb_frame_timing_gen;

    localparam int DV = 4;
    localparam int RC = 3;
    localparam int HF = 1;
    localparam int HB = 1;
    localparam int LG = 2;
    localparam int FG = 3;

    typedef struct packed {
        logic        fval;
        logic        lval;
        logic        dval;
        logic        fpos;
        logic        lneg;
        logic [15:0] pix;
        logic [15:0] line;
        logic [15:0] fcnt;
    } obs_t;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic en_a = 1'b0;
    logic en_b = 1'b0;

    logic        fval_a, lval_a, dval_a, fpos_a, lneg_a;
    logic [15:0] pix_a, line_a, fcnt_a;
    logic        fval_b, lval_b, dval_b, fpos_b, lneg_b;
    logic [15:0] pix_b, line_b, fcnt_b;

    always #5 clk = ~clk;

    frame_timing_gen #(.DVAL_HIGH(DV), .ROW_COUNT(RC), .H_FRONT(HF), .H_BACK(HB),
                       .LINE_GAP(LG), .FRAME_GAP(FG)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a),
        .fval(fval_a), .lval(lval_a), .dval(dval_a),
        .fval_posedge(fpos_a), .lval_negedge(lneg_a),
        .pix_x(pix_a), .line_idx(line_a), .frame_cnt(fcnt_a)
    );

    frame_timing_gen #(.DVAL_HIGH(DV), .ROW_COUNT(1), .H_FRONT(HF), .H_BACK(HB),
                       .LINE_GAP(LG), .FRAME_GAP(FG)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b),
        .fval(fval_b), .lval(lval_b), .dval(dval_b),
        .fval_posedge(fpos_b), .lval_negedge(lneg_b),
        .pix_x(pix_b), .line_idx(line_b), .frame_cnt(fcnt_b)
    );

    obs_t        qa[$];
    obs_t        qb[$];
    logic        pend[2];
    logic [15:0] fc_m[2];
    int          n_cmp = 0;
    int          n_bad = 0;
    obs_t        mon_ea, mon_eb, mon_oa, mon_ob;

    function automatic obs_t cur_a();
        return {fval_a, lval_a, dval_a, fpos_a, lneg_a, pix_a, line_a, fcnt_a};
    endfunction

    function automatic obs_t cur_b();
        return {fval_b, lval_b, dval_b, fpos_b, lneg_b, pix_b, line_b, fcnt_b};
    endfunction

    task automatic push_entry(input int which, input obs_t e);
        obs_t x;
        x = e;
        if (pend[which]) begin
            x.lneg = 1'b1;
            pend[which] = 1'b0;
        end
        if (which == 0) qa.push_back(x);
        else            qb.push_back(x);
    endtask

    // Expected cycles of one frame, starting with the first frame-gap cycle
    task automatic push_frame(input int which, input int rows);
        obs_t e;
        for (int i = 0; i < FG; i++) begin
            e = '0; e.fcnt = fc_m[which];
            push_entry(which, e);
        end
        fc_m[which] = fc_m[which] + 16'd1;
        for (int l = 0; l < rows; l++) begin
            for (int i = 0; i < HF; i++) begin
                e = '0; e.fval = 1'b1; e.lval = 1'b1; e.fpos = (l == 0 && i == 0);
                e.line = 16'(l); e.fcnt = fc_m[which];
                push_entry(which, e);
            end
            for (int i = 0; i < DV; i++) begin
                e = '0; e.fval = 1'b1; e.lval = 1'b1; e.dval = 1'b1; e.pix = 16'(i);
                e.line = 16'(l); e.fcnt = fc_m[which];
                push_entry(which, e);
            end
            for (int i = 0; i < HB; i++) begin
                e = '0; e.fval = 1'b1; e.lval = 1'b1; e.line = 16'(l); e.fcnt = fc_m[which];
                push_entry(which, e);
            end
            pend[which] = 1'b1;
            if (l < rows - 1) begin
                for (int i = 0; i < LG; i++) begin
                    e = '0; e.fval = 1'b1; e.line = 16'(l + 1); e.fcnt = fc_m[which];
                    push_entry(which, e);
                end
            end
        end
    endtask

    task automatic next_exp(input int which, output obs_t e);
        if (which == 0 && qa.size() > 0) begin
            e = qa.pop_front();
        end else if (which == 1 && qb.size() > 0) begin
            e = qb.pop_front();
        end else begin
            e = '0;
            e.fcnt = fc_m[which];
            if (pend[which]) begin
                e.lneg = 1'b1;
                pend[which] = 1'b0;
            end
        end
    endtask

    task automatic clear_models();
        qa.delete(); qb.delete();
        pend[0] = 1'b0; pend[1] = 1'b0;
        fc_m[0] = 16'd0; fc_m[1] = 16'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each falling edge consumes one expected cycle per instance
    always @(negedge clk) begin
        next_exp(0, mon_ea);
        next_exp(1, mon_eb);
        mon_oa = cur_a();
        mon_ob = cur_b();
        n_cmp++;
        if (mon_oa !== mon_ea) begin
            n_bad++;
            $display("FAIL sb_a t=%0t got f/l/d/fp/ln=%b%b%b%b%b pix=%0d line=%0d fcnt=%h exp f/l/d/fp/ln=%b%b%b%b%b pix=%0d line=%0d fcnt=%h",
                     $time, mon_oa.fval, mon_oa.lval, mon_oa.dval, mon_oa.fpos, mon_oa.lneg, mon_oa.pix, mon_oa.line, mon_oa.fcnt,
                     mon_ea.fval, mon_ea.lval, mon_ea.dval, mon_ea.fpos, mon_ea.lneg, mon_ea.pix, mon_ea.line, mon_ea.fcnt);
        end
        n_cmp++;
        if (mon_ob !== mon_eb) begin
            n_bad++;
            $display("FAIL sb_b t=%0t got f/l/d/fp/ln=%b%b%b%b%b pix=%0d line=%0d fcnt=%h exp f/l/d/fp/ln=%b%b%b%b%b pix=%0d line=%0d fcnt=%h",
                     $time, mon_ob.fval, mon_ob.lval, mon_ob.dval, mon_ob.fpos, mon_ob.lneg, mon_ob.pix, mon_ob.line, mon_ob.fcnt,
                     mon_eb.fval, mon_eb.lval, mon_eb.dval, mon_eb.fpos, mon_eb.lneg, mon_eb.pix, mon_eb.line, mon_eb.fcnt);
        end
    end

    task automatic test_reset();
        obs_t z;
        z = '0;
        rst = 1'b0; en_a = 1'b1; en_b = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (cur_a() !== z) begin n_bad++; $display("FAIL reset_a got %h exp %h", cur_a(), z); end
        n_cmp++;
        if (cur_b() !== z) begin n_bad++; $display("FAIL reset_b got %h exp %h", cur_b(), z); end
        en_a = 1'b0; en_b = 1'b0; rst = 1'b1;
        repeat (4) step();
        n_cmp++;
        if (cur_a() !== z) begin n_bad++; $display("FAIL idle_after_release got %h exp %h", cur_a(), z); end
    endtask

    task automatic test_continuous();
        int fpos_at[$];
        int lneg_n;
        logic [15:0] base;
        lneg_n = 0;
        base = fc_m[0];
        en_a = 1'b1;
        step();
        push_frame(0, RC); push_frame(0, RC); push_frame(0, RC);
        for (int k = 1; k <= 80; k++) begin
            if (k > 1) step();
            if (k == 55) en_a = 1'b0;
            if (fpos_a === 1'b1) begin
                fpos_at.push_back(k);
                n_cmp++;
                if (fcnt_a !== base + 16'(fpos_at.size())) begin
                    n_bad++; $display("FAIL cont_frame_cnt got %0d exp %0d", fcnt_a, base + 16'(fpos_at.size()));
                end
            end
            if (lneg_a === 1'b1) lneg_n++;
        end
        n_cmp++;
        if (fpos_at.size() != 3) begin
            n_bad++; $display("FAIL cont_fpos_count got %0d exp 3", fpos_at.size());
        end else begin
            n_cmp++;
            if (fpos_at[0] != 4) begin n_bad++; $display("FAIL cont_first_fpos got %0d exp 4", fpos_at[0]); end
            n_cmp++;
            if (fpos_at[1] - fpos_at[0] != 25) begin n_bad++; $display("FAIL cont_period1 got %0d exp 25", fpos_at[1] - fpos_at[0]); end
            n_cmp++;
            if (fpos_at[2] - fpos_at[1] != 25) begin n_bad++; $display("FAIL cont_period2 got %0d exp 25", fpos_at[2] - fpos_at[1]); end
        end
        n_cmp++;
        if (lneg_n != 9) begin n_bad++; $display("FAIL cont_lneg_count got %0d exp 9", lneg_n); end
    endtask

    task automatic run_one_frame(input string name, input int drop_k);
        int nf, nl, first_fpos;
        nf = 0; nl = 0; first_fpos = 0;
        en_a = 1'b1;
        step();
        push_frame(0, RC);
        for (int k = 1; k <= 32; k++) begin
            if (k > 1) step();
            if (k == drop_k) en_a = 1'b0;
            if (fpos_a === 1'b1) begin
                nf++;
                if (first_fpos == 0) first_fpos = k;
            end
            if (lneg_a === 1'b1) nl++;
        end
        n_cmp++;
        if (nf != 1) begin n_bad++; $display("FAIL %s_frames got %0d exp 1", name, nf); end
        n_cmp++;
        if (nl != 3) begin n_bad++; $display("FAIL %s_lines got %0d exp 3", name, nl); end
        n_cmp++;
        if (first_fpos != 4) begin n_bad++; $display("FAIL %s_fpos_at got %0d exp 4", name, first_fpos); end
        n_cmp++;
        if ({fval_a, lval_a, dval_a} !== 3'b000) begin
            n_bad++; $display("FAIL %s_idle got %b exp 000", name, {fval_a, lval_a, dval_a});
        end
    endtask

    task automatic test_stop_mid_frame();
        run_one_frame("stop_mid", 8);
    endtask

    task automatic test_enable_in_fgap();
        run_one_frame("drop_fgap", 2);
    endtask

    task automatic test_reset_mid_frame();
        en_a = 1'b1;
        step();
        push_frame(0, RC);
        for (int k = 2; k <= 13; k++) step();
        n_cmp++;
        if ({dval_a, line_a, pix_a} !== {1'b1, 16'd1, 16'd0}) begin
            n_bad++; $display("FAIL pre_reset_pos got dval=%b line=%0d pix=%0d exp dval=1 line=1 pix=0", dval_a, line_a, pix_a);
        end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({fval_a, lval_a, dval_a, lneg_a} !== 4'b0000) begin
            n_bad++; $display("FAIL async_reset_valids got %b exp 0000", {fval_a, lval_a, dval_a, lneg_a});
        end
        n_cmp++;
        if (fcnt_a !== 16'd0) begin n_bad++; $display("FAIL async_reset_fcnt got %0d exp 0", fcnt_a); end
        clear_models();
        #1 rst = 1'b1;
        run_one_frame("restart", 6);
    endtask

    task automatic test_wrap();
        force dut_a.frame_cnt_q = 16'hFFFF;
        fc_m[0] = 16'hFFFF;
        repeat (2) step();
        release dut_a.frame_cnt_q;
        step();
        en_a = 1'b1;
        step();
        push_frame(0, RC);
        for (int k = 2; k <= 30; k++) begin
            step();
            if (k == 5) en_a = 1'b0;
            if (k == 4) begin
                n_cmp++;
                if ({fpos_a, fcnt_a} !== {1'b1, 16'h0000}) begin
                    n_bad++; $display("FAIL wrap got fpos=%b fcnt=%h exp fpos=1 fcnt=0000", fpos_a, fcnt_a);
                end
            end
        end
    endtask

    task automatic test_single_row();
        int fpos_at[$];
        int fval_n, lneg_fall, lneg_n, lv_mis;
        logic prev_fval;
        fval_n = 0; lneg_fall = 0; lneg_n = 0; lv_mis = 0; prev_fval = 1'b0;
        en_b = 1'b1;
        step();
        push_frame(1, 1); push_frame(1, 1);
        for (int k = 1; k <= 22; k++) begin
            if (k > 1) step();
            if (k == 12) en_b = 1'b0;
            if (fpos_b === 1'b1) fpos_at.push_back(k);
            if (fval_b === 1'b1) fval_n++;
            if (lval_b !== fval_b) lv_mis++;
            if (lneg_b === 1'b1) begin
                lneg_n++;
                if (prev_fval === 1'b1 && fval_b === 1'b0) lneg_fall++;
            end
            prev_fval = fval_b;
        end
        n_cmp++;
        if (fpos_at.size() != 2) begin
            n_bad++; $display("FAIL row1_fpos_count got %0d exp 2", fpos_at.size());
        end else begin
            n_cmp++;
            if (fpos_at[1] - fpos_at[0] != 9) begin n_bad++; $display("FAIL row1_period got %0d exp 9", fpos_at[1] - fpos_at[0]); end
        end
        n_cmp++;
        if (fval_n != 12) begin n_bad++; $display("FAIL row1_fval_cycles got %0d exp 12", fval_n); end
        n_cmp++;
        if (lv_mis != 0) begin n_bad++; $display("FAIL row1_lval_eq_fval got %0d exp 0", lv_mis); end
        n_cmp++;
        if (lneg_n != 2 || lneg_fall != 2) begin
            n_bad++; $display("FAIL row1_lneg got total=%0d on_fall=%0d exp 2/2", lneg_n, lneg_fall);
        end
    endtask

    initial begin
        clear_models();
        test_reset();
        test_continuous();
        test_stop_mid_frame();
        test_enable_in_fgap();
        test_reset_mid_frame();
        test_wrap();
        test_single_row();
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
